// File: rtl/time_set_entry.sv
// Button-driven BCD time-entry controller. Debounces four buttons, edits an
// hh:mm:ss buffer and, on confirm, strobes hour, minute and second digits out
// on set1:set0 with a one-cycle load per field.
module time_set_entry #(
    parameter int unsigned DEB_CYCLES   = 500000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned TIMEOUT      = 500000000
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_ok,
    output logic [3:0] set0,
    output logic [3:0] set1,
    output logic [1:0] field,
    output logic       load,
    output logic       EN_setalarm
);
    localparam int unsigned DCW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RCW  = $clog2(RMAX + 1);
    localparam int unsigned TCW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StEditHour, StEditMin, StEditSec, StCommit0, StCommit1, StCommit2
    } state_t;

    // Button bit order: 0 mode, 1 up, 2 down, 3 ok.
    logic [3:0]     r_sync1, r_sync2, r_deb;
    logic [DCW-1:0] r_dcnt [4];
    logic [3:0]     w_press;
    // Auto-repeat, index 0 up, 1 down.
    logic [RCW-1:0] r_rcnt [2];
    logic [1:0]     r_rfirst;
    logic [1:0]     w_rep;

    state_t         r_state, w_state_d;
    logic [7:0]     r_buf_h, r_buf_m, r_buf_s;
    logic [7:0]     r_com_h, r_com_m, r_com_s;
    logic [7:0]     r_disp;
    logic [TCW-1:0] r_idle;

    logic           w_ev_mode, w_ev_up, w_ev_dn, w_ev_ok, w_any_ev;
    logic           w_editing, w_copy_in, w_copy_out, w_step, w_step_up;
    logic [1:0]     w_sel;
    logic [7:0]     w_sel_bcd, w_stepped;

    // One BCD step of a {tens, ones} pair; hours wrap at 24, others at 60.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic hour);
        logic [3:0] t, o;
        t = v[7:4];
        o = v[3:0];
        if (up) begin
            if ((hour && t == 4'd2 && o == 4'd3) || (!hour && t == 4'd5 && o == 4'd9))
                return 8'h00;
            else if (o == 4'd9) return {t + 4'd1, 4'd0};
            else return {t, o + 4'd1};
        end else begin
            if (t == 4'd0 && o == 4'd0) return hour ? 8'h23 : 8'h59;
            else if (o == 4'd0) return {t - 4'd1, 4'd9};
            else return {t, o - 4'd1};
        end
    endfunction

    // Synchronize raw buttons, then flip the debounced level after a stable run.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < 4; i++) r_dcnt[i] <= '0;
        end else begin
            r_sync1 <= {btn_ok, btn_down, btn_up, btn_mode};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DCW'(DEB_CYCLES - 1)) begin
                    r_deb[i]  <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + DCW'(1);
                end
            end
        end
    end

    // Press event fires in the cycle the debounced level is about to rise.
    always_comb begin
        w_press = '0;
        for (int i = 0; i < 4; i++)
            w_press[i] = r_sync2[i] & ~r_deb[i] & (r_dcnt[i] == DCW'(DEB_CYCLES - 1));
    end

    // Repeat fires REPEAT_DELAY cycles after the press, then every REPEAT_RATE.
    always_comb begin
        w_rep = '0;
        for (int j = 0; j < 2; j++)
            w_rep[j] = r_deb[j+1] & (r_rfirst[j] ? (r_rcnt[j] == RCW'(REPEAT_RATE))
                                                  : (r_rcnt[j] == RCW'(REPEAT_DELAY)));
    end

    // Auto-repeat counters for up/down, cleared whenever the button is released.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_rfirst <= '0;
            for (int j = 0; j < 2; j++) r_rcnt[j] <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (w_press[j+1]) begin
                    r_rcnt[j]   <= RCW'(1);
                    r_rfirst[j] <= 1'b0;
                end else if (!r_deb[j+1]) begin
                    r_rcnt[j]   <= '0;
                    r_rfirst[j] <= 1'b0;
                end else if (w_rep[j]) begin
                    r_rcnt[j]   <= RCW'(1);
                    r_rfirst[j] <= 1'b1;
                end else begin
                    r_rcnt[j] <= r_rcnt[j] + RCW'(1);
                end
            end
        end
    end

    assign w_ev_mode = w_press[0];
    assign w_ev_up   = w_press[1] | w_rep[0];
    assign w_ev_dn   = w_press[2] | w_rep[1];
    assign w_ev_ok   = w_press[3];
    assign w_any_ev  = w_ev_mode | w_ev_up | w_ev_dn | w_ev_ok;
    assign w_editing = (r_state == StEditHour) || (r_state == StEditMin) ||
                       (r_state == StEditSec);

    // Field code of the field being edited or committed, and its buffer digits.
    always_comb begin
        w_sel = 2'd0;
        case (r_state)
            StEditHour, StCommit0: w_sel = 2'd2;
            StEditMin,  StCommit1: w_sel = 2'd1;
            default:               w_sel = 2'd0;
        endcase
        w_sel_bcd = r_buf_s;
        case (w_sel)
            2'd2:    w_sel_bcd = r_buf_h;
            2'd1:    w_sel_bcd = r_buf_m;
            default: w_sel_bcd = r_buf_s;
        endcase
        w_stepped = bcd_step(w_sel_bcd, w_step_up, w_sel == 2'd2);
    end

    // Next-state decode and output drive; ok beats mode, and mode beats a step.
    always_comb begin
        w_state_d   = r_state;
        w_copy_in   = 1'b0;
        w_copy_out  = 1'b0;
        w_step      = 1'b0;
        w_step_up   = 1'b0;
        set0        = 4'd0;
        set1        = 4'd0;
        field       = 2'd0;
        load        = 1'b0;
        EN_setalarm = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_ev_mode) begin
                    w_state_d = StEditHour;
                    w_copy_in = 1'b1;
                end
            end
            StEditHour, StEditMin, StEditSec: begin
                EN_setalarm = 1'b1;
                field       = w_sel;
                {set1, set0} = r_disp;
                if (w_ev_ok) begin
                    w_state_d = StCommit0;
                end else if (w_ev_mode) begin
                    w_state_d = (r_state == StEditHour) ? StEditMin :
                                (r_state == StEditMin)  ? StEditSec : StEditHour;
                end else if (w_ev_up ^ w_ev_dn) begin
                    w_step    = 1'b1;
                    w_step_up = w_ev_up;
                end else if (!w_any_ev && r_idle == TCW'(TIMEOUT - 1)) begin
                    w_state_d = StIdle;
                end
            end
            StCommit0, StCommit1, StCommit2: begin
                EN_setalarm  = 1'b1;
                load         = 1'b1;
                field        = w_sel;
                {set1, set0} = w_sel_bcd;
                if (r_state == StCommit0)      w_state_d = StCommit1;
                else if (r_state == StCommit1) w_state_d = StCommit2;
                else begin
                    w_state_d  = StIdle;
                    w_copy_out = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, edit buffer, committed copy, display register and idle timer.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= StIdle;
            r_buf_h <= '0;
            r_buf_m <= '0;
            r_buf_s <= '0;
            r_com_h <= '0;
            r_com_m <= '0;
            r_com_s <= '0;
            r_disp  <= '0;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_d;
            r_disp  <= w_sel_bcd;
            if (w_copy_in) begin
                r_buf_h <= r_com_h;
                r_buf_m <= r_com_m;
                r_buf_s <= r_com_s;
            end else if (w_step) begin
                case (w_sel)
                    2'd2:    r_buf_h <= w_stepped;
                    2'd1:    r_buf_m <= w_stepped;
                    default: r_buf_s <= w_stepped;
                endcase
            end
            if (w_copy_out) begin
                r_com_h <= r_buf_h;
                r_com_m <= r_buf_m;
                r_com_s <= r_buf_s;
            end
            if (!w_editing || w_any_ev) r_idle <= '0;
            else                        r_idle <= r_idle + TCW'(1);
        end
    end
endmodule

// File: tb/tb_time_set_entry.sv
// Self-checking bench for time_set_entry with short timing parameters.
module tb_time_set_entry;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RR  = 5;
    localparam int unsigned TO  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'd0;  // 0 mode, 1 up, 2 down, 3 ok
    logic [3:0] set0, set1;
    logic [1:0] field;
    logic       load, en;

    int n_chk = 0;
    int n_fail = 0;
    int n_loads = 0;

    // Reference model: field values as plain integers; sel 2 hour, 1 min, 0 sec.
    int m_buf[3];
    int m_com[3];
    int m_sel = 2;
    bit m_edit = 1'b0;

    time_set_entry #(
        .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO)
    ) dut (
        .CLK(clk), .RST_n(rst_n),
        .btn_mode(btn[0]), .btn_up(btn[1]), .btn_down(btn[2]), .btn_ok(btn[3]),
        .set0(set0), .set1(set1), .field(field), .load(load), .EN_setalarm(en)
    );

    always #5 clk = ~clk;

    // Count cycles with load high, sampled mid-cycle.
    always @(negedge clk) if (load === 1'b1) n_loads++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int modv(input int s);
        return (s == 2) ? 24 : 60;
    endfunction

    // Events produced by holding a raw button h cycles.
    function automatic int n_events(input int b, input int h);
        if (h < int'(DEB)) return 0;
        if ((b == 1 || b == 2) && h >= int'(RD)) return 2 + (h - int'(RD)) / int'(RR);
        return 1;
    endfunction

    task automatic model_apply(input int b, input int n);
        for (int k = 0; k < n; k++) begin
            if (!m_edit) begin
                if (b == 0) begin
                    m_edit = 1'b1;
                    m_sel  = 2;
                    m_buf  = m_com;
                end
            end else if (b == 0) begin
                m_sel = (m_sel == 0) ? 2 : m_sel - 1;
            end else if (b == 1) begin
                m_buf[m_sel] = (m_buf[m_sel] + 1) % modv(m_sel);
            end else if (b == 2) begin
                m_buf[m_sel] = (m_buf[m_sel] + modv(m_sel) - 1) % modv(m_sel);
            end
        end
    endtask

    task automatic press(input int b, input int h);
        btn[b] = 1'b1;
        cyc(h);
        btn[b] = 1'b0;
        cyc(DEB + 4);
        model_apply(b, n_events(b, h));
    endtask

    task automatic chk_disp(input string tag);
        int v;
        v = m_edit ? m_buf[m_sel] : 0;
        chk({tag, "_set1"}, 8'(set1), 8'(v / 10));
        chk({tag, "_set0"}, 8'(set0), 8'(v % 10));
        chk({tag, "_field"}, 8'(field), m_edit ? 8'(m_sel) : 8'd0);
        chk({tag, "_en"}, 8'(en), 8'(m_edit));
        chk({tag, "_load"}, 8'(load), 8'd0);
    endtask

    // Check one commit strobe cycle against the model buffer.
    task automatic chk_commit(input string tag, input int s);
        chk({tag, "_load"}, 8'(load), 8'd1);
        chk({tag, "_field"}, 8'(field), 8'(s));
        chk({tag, "_digits"}, {set1, set0}, 8'(((m_buf[s] / 10) << 4) | (m_buf[s] % 10)));
    endtask

    initial begin
        int tgt[3];
        int loads0;
        int rem;
        for (int i = 0; i < 3; i++) begin
            m_buf[i] = 0;
            m_com[i] = 0;
        end

        // Reset state
        cyc(3);
        chk_disp("reset");
        rst_n = 1'b1;
        cyc(2);

        // Debounce: short glitch ignored, full press enters edit after 2+DEB edges
        btn[0] = 1'b1;
        cyc(DEB - 1);
        btn[0] = 1'b0;
        cyc(DEB + 4);
        chk("glitch_en", 8'(en), 8'd0);
        btn[0] = 1'b1;
        cyc(DEB + 1);
        chk("pre_latency_en", 8'(en), 8'd0);
        cyc(1);
        chk("latency_en", 8'(en), 8'd1);
        cyc(10 - DEB - 2);
        btn[0] = 1'b0;
        cyc(DEB + 4);
        model_apply(0, 1);
        chk_disp("enter");

        // Hour wraps down 00 -> 23
        press(2, 5);
        chk("hour_wrap", {set1, set0}, 8'h23);
        chk_disp("hour_wrap_m");

        // Minutes: 60 ups from 00 back to 00, passing 09 -> 10
        press(0, 5);
        for (int i = 1; i <= 60; i++) begin
            press(1, 5);
            if (i == 9)  chk("min_09", {set1, set0}, 8'h09);
            if (i == 10) chk("min_10", {set1, set0}, 8'h10);
        end
        chk("min_wrap", {set1, set0}, 8'h00);
        chk_disp("min_wrap_m");

        // Auto-repeat in seconds from 00: 1 press + 1 delayed + 6 rate steps
        press(0, 5);
        press(1, RD + 6 * RR + 4);
        chk("auto_repeat", {set1, set0}, 8'h08);
        chk_disp("auto_repeat_m");

        // Random button activity against the model
        for (int i = 0; i < 12; i++) begin
            press(int'($urandom_range(0, 2)), int'($urandom_range(DEB, 45)));
            chk_disp("rnd");
        end

        // Commit 12:34:56
        tgt[2] = 12;
        tgt[1] = 34;
        tgt[0] = 56;
        for (int s = 2; s >= 0; s--) begin
            for (int k = 0; k < 3 && m_sel != s; k++) press(0, 5);
            for (int k = 0; k < 60 && m_buf[s] != tgt[s]; k++) press(1, 5);
        end
        chk_disp("pre_commit");
        btn[3] = 1'b1;
        cyc(DEB + 2);
        chk_commit("commit0", 2);
        chk("commit0_val", {set1, set0}, 8'h12);
        cyc(1);
        chk_commit("commit1", 1);
        chk("commit1_val", {set1, set0}, 8'h34);
        cyc(1);
        chk_commit("commit2", 0);
        chk("commit2_val", {set1, set0}, 8'h56);
        cyc(1);
        m_com  = m_buf;
        m_edit = 1'b0;
        chk_disp("post_commit");
        btn[3] = 1'b0;
        cyc(DEB + 4);

        // Timeout: edit hour to 05, idle, edit discarded without a strobe
        loads0 = n_loads;
        press(0, 5);
        chk_disp("reenter_commit");
        for (int k = 0; k < 24 && m_buf[2] != 5; k++) press(2, 5);
        chk("hour_05", {set1, set0}, 8'h05);
        rem = int'(DEB) + 2 + int'(TO) - (5 + int'(DEB) + 4);
        cyc(rem - 1);
        chk("pre_timeout_en", 8'(en), 8'd1);
        cyc(1);
        chk("timeout_en", 8'(en), 8'd0);
        m_edit = 1'b0;
        press(0, 5);
        chk_disp("after_timeout");
        chk("after_timeout_hour", {set1, set0}, 8'h12);
        chk("timeout_no_load", 8'(n_loads - loads0), 8'd0);

        // up and down together: no step
        btn[1] = 1'b1;
        btn[2] = 1'b1;
        cyc(5);
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        cyc(DEB + 4);
        chk_disp("up_down");

        // ok with mode: commit wins
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        cyc(DEB + 2);
        chk_commit("ok_mode", 2);
        cyc(3);
        btn[0] = 1'b0;
        btn[3] = 1'b0;
        m_com  = m_buf;
        m_edit = 1'b0;
        cyc(DEB + 4);
        chk_disp("ok_mode_idle");

        // ok with up: step discarded, commit proceeds
        press(0, 5);
        btn[1] = 1'b1;
        btn[3] = 1'b1;
        cyc(DEB + 2);
        chk_commit("ok_up", 2);
        cyc(3);
        btn[1] = 1'b0;
        btn[3] = 1'b0;
        m_com  = m_buf;
        m_edit = 1'b0;
        cyc(DEB + 4);
        press(0, 5);
        chk_disp("ok_up_reenter");

        // Reset during COMMIT1 aborts at once
        press(1, 5);
        btn[3] = 1'b1;
        cyc(DEB + 3);
        chk_commit("pre_rst_commit1", 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_load", 8'(load), 8'd0);
        chk("rst_en", 8'(en), 8'd0);
        chk("rst_field", 8'(field), 8'd0);
        chk("rst_digits", {set1, set0}, 8'h00);
        btn[3] = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) m_com[i] = 0;
        m_edit = 1'b0;
        cyc(DEB + 4);
        press(0, 5);
        chk_disp("after_rst");
        chk("after_rst_hour", {set1, set0}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
